rom_dl_sequencer: RTL and testbench

- Sits between the HPS ioctl download stream and the game core's ROM/PROM write ports.
- Decodes the flat download address into per-region write strobes (program, graphics, sound, palette PROM) and presents a region-relative address.
- Holds the core in reset from download start until a fixed settle delay after the last byte has been written.
- Flags short or overrun downloads.

---
 rtl/kb_dl_pkg.sv | 38 +++
 rtl/rom_region_decode.sv | 44 ++++
 rtl/rom_dl_sequencer.sv | 147 ++++++++++++++
 tb/tb_rom_dl_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kb_dl_pkg.sv
// Shared types and address-map helper for the HPS ROM download path.
package kb_dl_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 17;

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, HOLD, RUN} state_e;

  typedef enum logic [2:0] {RGN_PRG, RGN_GFX, RGN_SND, RGN_PROM, RGN_NONE} region_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } dl_beat_t;

  // Base offset of each region in the flat map; RGN_NONE yields the end of the map.
  function automatic logic [CNT_W-1:0] region_base(
    input region_e           rgn,
    input logic [ADDR_W-1:0] prg_size,
    input logic [ADDR_W-1:0] gfx_size,
    input logic [ADDR_W-1:0] snd_size,
    input logic [ADDR_W-1:0] prom_size
  );
    logic [CNT_W-1:0] base;
    base = '0;
    case (rgn)
      RGN_PRG:  base = '0;
      RGN_GFX:  base = CNT_W'(prg_size);
      RGN_SND:  base = CNT_W'(prg_size) + CNT_W'(gfx_size);
      RGN_PROM: base = CNT_W'(prg_size) + CNT_W'(gfx_size) + CNT_W'(snd_size);
      default:  base = CNT_W'(prg_size) + CNT_W'(gfx_size) + CNT_W'(snd_size)
                     + CNT_W'(prom_size);
    endcase
    return base;
  endfunction

endpackage

// File: rtl/rom_region_decode.sv
// Flat download address to region index and region-relative address.
module rom_region_decode
  import kb_dl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PRG_SIZE  = 16'h3000,
  parameter logic [ADDR_W-1:0] GFX_SIZE  = 16'h1000,
  parameter logic [ADDR_W-1:0] SND_SIZE  = 16'h1800,
  parameter logic [ADDR_W-1:0] PROM_SIZE = 16'h0020
) (
  input  logic [ADDR_W-1:0] addr,
  output region_e           region_c,
  output logic [ADDR_W-1:0] rel_addr_c
);

  localparam logic [CNT_W-1:0] GFX_BASE  = region_base(RGN_GFX,  PRG_SIZE, GFX_SIZE, SND_SIZE, PROM_SIZE);
  localparam logic [CNT_W-1:0] SND_BASE  = region_base(RGN_SND,  PRG_SIZE, GFX_SIZE, SND_SIZE, PROM_SIZE);
  localparam logic [CNT_W-1:0] PROM_BASE = region_base(RGN_PROM, PRG_SIZE, GFX_SIZE, SND_SIZE, PROM_SIZE);
  localparam logic [CNT_W-1:0] MAP_END   = region_base(RGN_NONE, PRG_SIZE, GFX_SIZE, SND_SIZE, PROM_SIZE);

  logic [CNT_W-1:0] addr_x;
  logic [CNT_W-1:0] base;

  // Bounds compared 17 bits wide so a map ending at 64K cannot wrap.
  always_comb begin
    addr_x   = CNT_W'(addr);
    region_c = RGN_NONE;
    base     = '0;
    if (addr_x < GFX_BASE) begin
      region_c = RGN_PRG;
      base     = '0;
    end else if (addr_x < SND_BASE) begin
      region_c = RGN_GFX;
      base     = GFX_BASE;
    end else if (addr_x < PROM_BASE) begin
      region_c = RGN_SND;
      base     = SND_BASE;
    end else if (addr_x < MAP_END) begin
      region_c = RGN_PROM;
      base     = PROM_BASE;
    end
    rel_addr_c = ADDR_W'(addr_x - base);
  end

endmodule

// File: rtl/rom_dl_sequencer.sv
// Routes the HPS ioctl download into per-region ROM write ports and
// sequences the game core reset around the download.
module rom_dl_sequencer
  import kb_dl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PRG_SIZE    = 16'h3000,
  parameter logic [ADDR_W-1:0] GFX_SIZE    = 16'h1000,
  parameter logic [ADDR_W-1:0] SND_SIZE    = 16'h1800,
  parameter logic [ADDR_W-1:0] PROM_SIZE   = 16'h0020,
  parameter int unsigned       RELEASE_CYC = 1024
) (
  input  logic              clk_sys,
  input  logic              I_RESET_n,
  input  logic              dn_download,
  input  logic              dn_wr,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [DATA_W-1:0] dn_data,
  input  logic              reset_req,
  output logic              wr_prg,
  output logic              wr_gfx,
  output logic              wr_snd,
  output logic              wr_prom,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              core_reset,
  output logic              dl_busy,
  output logic              dl_error,
  output logic [CNT_W-1:0]  dl_count
);

  localparam int unsigned      HOLD_W    = $clog2(RELEASE_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RELEASE_CYC - 1);
  localparam logic [CNT_W-1:0] TOTAL     = region_base(RGN_NONE, PRG_SIZE, GFX_SIZE, SND_SIZE, PROM_SIZE);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              dl_q;
  logic              dl_rise, dl_fall, accept;
  region_e           rgn_c;
  logic [ADDR_W-1:0] rel_addr_c;
  logic [CNT_W-1:0]  count_nxt;
  logic              error_nxt;
  dl_beat_t          beat_q;

  rom_region_decode #(
    .PRG_SIZE  (PRG_SIZE),
    .GFX_SIZE  (GFX_SIZE),
    .SND_SIZE  (SND_SIZE),
    .PROM_SIZE (PROM_SIZE)
  ) u_decode (
    .addr       (dn_addr),
    .region_c   (rgn_c),
    .rel_addr_c (rel_addr_c)
  );

  always_comb begin
    dl_rise = dn_download & ~dl_q;
    dl_fall = ~dn_download & dl_q;
    accept  = (state == LOAD) & dn_wr;
  end

  always_ff @(posedge clk_sys or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      state    <= HOLD;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // A new download may preempt the release countdown or a running core.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      IDLE: begin
        state_nxt    = dl_rise ? LOAD : HOLD;
        hold_cnt_nxt = '0;
      end
      LOAD: begin
        if (dl_fall) state_nxt = FLUSH;
      end
      FLUSH: begin
        state_nxt    = HOLD;
        hold_cnt_nxt = '0;
      end
      HOLD: begin
        if (dl_rise)                    state_nxt    = LOAD;
        else if (hold_cnt == HOLD_LAST) state_nxt    = RUN;
        else                            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
      end
      RUN: begin
        if (dl_rise) state_nxt = LOAD;
      end
      default: begin
        state_nxt    = HOLD;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // The short check sees the count including a write landing on the falling edge.
  always_comb begin
    count_nxt = dl_count;
    error_nxt = dl_error;
    if (state_nxt == LOAD && state != LOAD) begin
      count_nxt = '0;
      error_nxt = 1'b0;
    end else begin
      if (accept && dl_count != CNT_MAX) count_nxt = dl_count + CNT_W'(1);
      if (accept && rgn_c == RGN_NONE)   error_nxt = 1'b1;
      if (state == LOAD && dl_fall && count_nxt < TOTAL) error_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      dl_q       <= 1'b0;
      wr_prg     <= 1'b0;
      wr_gfx     <= 1'b0;
      wr_snd     <= 1'b0;
      wr_prom    <= 1'b0;
      beat_q     <= '0;
      core_reset <= 1'b1;
      dl_busy    <= 1'b0;
      dl_error   <= 1'b0;
      dl_count   <= '0;
    end else begin
      dl_q       <= dn_download;
      wr_prg     <= accept && (rgn_c == RGN_PRG);
      wr_gfx     <= accept && (rgn_c == RGN_GFX);
      wr_snd     <= accept && (rgn_c == RGN_SND);
      wr_prom    <= accept && (rgn_c == RGN_PROM);
      if (accept && rgn_c != RGN_NONE) beat_q <= '{addr: rel_addr_c, data: dn_data};
      core_reset <= (state != RUN) | reset_req;
      dl_busy    <= (state_nxt == LOAD) || (state_nxt == FLUSH);
      dl_error   <= error_nxt;
      dl_count   <= count_nxt;
    end
  end

  assign wr_addr = beat_q.addr;
  assign wr_data = beat_q.data;

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Randomized scoreboard bench for rom_dl_sequencer against an address-map reference model.
module tb_rom_dl_sequencer;

  localparam int P_SZ  = 32'h3000;
  localparam int G_SZ  = 32'h1000;
  localparam int S_SZ  = 32'h1800;
  localparam int R_SZ  = 32'h0020;
  localparam int TOTAL = P_SZ + G_SZ + S_SZ + R_SZ;
  localparam int REL   = 1024;

  logic        clk_sys     = 1'b0;
  logic        I_RESET_n   = 1'b0;
  logic        dn_download = 1'b0;
  logic        dn_wr       = 1'b0;
  logic [15:0] dn_addr     = '0;
  logic [7:0]  dn_data     = '0;
  logic        reset_req   = 1'b0;
  logic        wr_prg, wr_gfx, wr_snd, wr_prom;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        core_reset, dl_busy, dl_error;
  logic [16:0] dl_count;

  typedef struct {
    int rgn;
    int addr;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   exp_count = 0;
  bit   exp_err   = 1'b0;
  int   n_strobe[4];

  always #5 clk_sys = ~clk_sys;

  rom_dl_sequencer dut (
    .clk_sys     (clk_sys),
    .I_RESET_n   (I_RESET_n),
    .dn_download (dn_download),
    .dn_wr       (dn_wr),
    .dn_addr     (dn_addr),
    .dn_data     (dn_data),
    .reset_req   (reset_req),
    .wr_prg      (wr_prg),
    .wr_gfx      (wr_gfx),
    .wr_snd      (wr_snd),
    .wr_prom     (wr_prom),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .core_reset  (core_reset),
    .dl_busy     (dl_busy),
    .dl_error    (dl_error),
    .dl_count    (dl_count)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference map: region 0..3 = PRG/GFX/SND/PROM, 4 = outside the image.
  function automatic void ref_map(input int a, output int rgn, output int rel);
    if (a < P_SZ)                     begin rgn = 0; rel = a; end
    else if (a < P_SZ + G_SZ)         begin rgn = 1; rel = a - P_SZ; end
    else if (a < P_SZ + G_SZ + S_SZ)  begin rgn = 2; rel = a - P_SZ - G_SZ; end
    else if (a < TOTAL)               begin rgn = 3; rel = a - P_SZ - G_SZ - S_SZ; end
    else                              begin rgn = 4; rel = 0; end
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_wr(input int a, input bit track);
    int rgn, rel;
    logic [7:0] d;
    d       = 8'($urandom);
    dn_wr   = 1'b1;
    dn_addr = 16'(a);
    dn_data = d;
    ref_map(a, rgn, rel);
    if (track) begin
      if (rgn != 4) exp_q.push_back('{rgn, rel, int'(d)});
      else          exp_err = 1'b1;
      exp_count++;
    end
    tick();
    dn_wr = 1'b0;
  endtask

  task automatic start_dl();
    dn_download = 1'b1;
    tick();
    exp_count = 0;
    exp_err   = 1'b0;
    check("load_busy", dl_busy, 1);
    check("load_count_clr", dl_count, 0);
    check("load_err_clr", dl_error, 0);
  endtask

  task automatic end_dl();
    dn_wr       = 1'b0;
    dn_download = 1'b0;
    tick();
    if (exp_count < TOTAL) exp_err = 1'b1;
    @(negedge clk_sys);
    check("flush_busy", dl_busy, 1);
    check("end_count", dl_count, exp_count);
    check("end_error", dl_error, exp_err);
  endtask

  task automatic wait_run(output int n);
    n = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk_sys);
      n++;
      @(negedge clk_sys);
      if (!core_reset) return;
    end
    n = -1;
  endtask

  task automatic count_release(output int n, output int nbusy);
    n     = 0;
    nbusy = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk_sys);
      if (dl_busy) nbusy++;
      if (core_reset) n++;
      else return;
    end
    n = -1;
  endtask

  // Monitor: every strobe must match the oldest outstanding accepted write.
  always @(negedge clk_sys) begin
    if (I_RESET_n && (wr_prg | wr_gfx | wr_snd | wr_prom)) begin
      int   got;
      exp_t e;
      got = wr_prg ? 0 : wr_gfx ? 1 : wr_snd ? 2 : 3;
      check("strobe_onehot", $countones({wr_prg, wr_gfx, wr_snd, wr_prom}), 1);
      n_strobe[got]++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL strobe_unexpected: region %0d addr %0h seen, none pending", got, wr_addr);
      end else begin
        e = exp_q.pop_front();
        check("strobe_region", got, e.rgn);
        check("strobe_addr", wr_addr, e.addr);
        check("strobe_data", wr_data, e.data);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb, lows;
    int blist[10];
    for (int i = 0; i < 4; i++) n_strobe[i] = 0;

    // Reset values, then the release countdown with no download.
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_core_reset", core_reset, 1);
    check("rst_strobes", {wr_prg, wr_gfx, wr_snd, wr_prom}, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", dl_busy, 0);
    check("rst_error", dl_error, 0);
    check("rst_count", dl_count, 0);
    @(posedge clk_sys);
    #1 I_RESET_n = 1'b1;
    count_release(n, nb);
    check("release_len", n, REL + 1);
    check("release_busy", nb, 0);

    // Full download, back-to-back writes.
    start_dl();
    for (int a = 0; a < TOTAL; a++) drive_wr(a, 1'b1);
    end_dl();
    check("n_prg", n_strobe[0], P_SZ);
    check("n_gfx", n_strobe[1], G_SZ);
    check("n_snd", n_strobe[2], S_SZ);
    check("n_prom", n_strobe[3], R_SZ);
    check("full_drained", exp_q.size(), 0);
    wait_run(n);
    check("full_release", n, REL + 2);

    // Short download with random gaps.
    start_dl();
    for (int a = 0; a < 32'h1000; a++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      drive_wr(a, 1'b1);
    end
    end_dl();
    check("short_error", dl_error, 1);
    wait_run(n);
    check("short_release", n, REL + 2);

    // Overrun: first write beyond the image, then random out-of-range writes.
    start_dl();
    for (int i = 0; i < 20; i++) drive_wr($urandom_range(0, TOTAL - 1), 1'b1);
    drive_wr(TOTAL, 1'b1);
    @(negedge clk_sys);
    check("overrun_error", dl_error, 1);
    check("overrun_count", dl_count, exp_count);
    for (int i = 0; i < 5; i++) drive_wr($urandom_range(TOTAL, 16'hFFFF), 1'b1);
    end_dl();

    // New download while the release counter sits at 500.
    lows = 0;
    for (int i = 0; i < 501; i++) begin
      tick();
      if (!core_reset) lows++;
    end
    dn_download = 1'b1;
    tick();
    exp_count = 0;
    exp_err   = 1'b0;
    check("hold_core_reset", lows, 0);
    check("hold_load_busy", dl_busy, 1);
    check("hold_load_count", dl_count, 0);
    check("hold_load_err", dl_error, 0);
    check("hold_load_core", core_reset, 1);

    // Region boundaries plus random in-range addresses.
    blist = '{0, 1, 32'h2FFF, 32'h3000, 32'h3001, 32'h3FFF, 32'h4000, 32'h57FF, 32'h5800, 32'h581F};
    for (int i = 0; i < 10; i++) drive_wr(blist[i], 1'b1);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
      drive_wr($urandom_range(0, TOTAL - 1), 1'b1);
    end
    end_dl();

    // Reset asserted mid-load right after byte 0x100 is taken.
    idle(3);
    start_dl();
    for (int a = 0; a < 32'h100; a++) drive_wr(a, 1'b1);
    dn_wr   = 1'b1;
    dn_addr = 16'h0100;
    dn_data = 8'($urandom);
    tick();
    I_RESET_n   = 1'b0;
    dn_wr       = 1'b0;
    dn_download = 1'b0;
    #1;
    check("midrst_strobes", {wr_prg, wr_gfx, wr_snd, wr_prom}, 0);
    check("midrst_count", dl_count, 0);
    check("midrst_core", core_reset, 1);
    check("midrst_busy", dl_busy, 0);
    repeat (2) @(posedge clk_sys);
    #1 I_RESET_n = 1'b1;
    count_release(n, nb);
    check("midrst_release", n, REL + 1);
    check("midrst_rel_busy", nb, 0);
    check("midrst_count_after", dl_count, 0);
    check("midrst_err_after", dl_error, 0);

    // reset_req pulse of 3 cycles while running.
    @(posedge clk_sys);
    #1 reset_req = 1'b1;
    @(negedge clk_sys);
    check("req_delay", core_reset, 0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk_sys);
      #1;
      if (i == 3) reset_req = 1'b0;
      @(negedge clk_sys);
      check("req_high", core_reset, 1);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk_sys);
      check("req_low", core_reset, 0);
    end
    check("req_busy", dl_busy, 0);

    idle(2);
    check("final_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
